vx_wb_arbiter: RTL

VX_WB_ARBITER -- requirements
Module: VX_wb_arbiter

---
 rtl/vx_wb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/vx_wb_arbiter.sv
// Writeback arbiter: round-robin over commit sources, packet-locked until eop, 1-deep registered output.
// Optional contention counter on perf_stalls when VX_WB_ARB_PERF_EN is defined.
module vx_wb_arbiter #(
   parameter int NUM_REQS = 5,
   parameter int DATAW    = 64
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_REQS-1:0]                in_valid,
   input  logic [NUM_REQS-1:0][DATAW-1:0]     in_data,
   input  logic [NUM_REQS-1:0]                in_eop,
   output logic [NUM_REQS-1:0]                in_ready,
   output logic                               out_valid,
   output logic [DATAW-1:0]                   out_data,
   output logic [$clog2(NUM_REQS)-1:0]        out_sel,
   input  logic                               out_ready
`ifdef VX_WB_ARB_PERF_EN
   ,
   output logic [31:0]                        perf_stalls
`endif
);

   localparam int SELW = $clog2(NUM_REQS);

   logic [SELW-1:0] rr_ptr;
   logic [SELW-1:0] lock_idx;
   logic            lock;

   logic [SELW-1:0] grant_idx;
   logic            grant_vld;
   logic            enable;
   logic            fire;
   logic [SELW-1:0] rr_next;

   // Locked packets own the port: no fallback search, an idle owner yields a bubble.
   always_comb begin
      int idx;
      idx       = 0;
      grant_idx = '0;
      grant_vld = 1'b0;
      if (lock) begin
         grant_idx = lock_idx;
         grant_vld = in_valid[lock_idx];
      end else begin
         for (int k = 0; k < NUM_REQS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQS) idx = idx - NUM_REQS;
            if (!grant_vld && in_valid[idx]) begin
               grant_vld = 1'b1;
               grant_idx = SELW'(idx);
            end
         end
      end
   end

   assign enable  = !out_valid || out_ready;
   assign fire    = grant_vld && enable && !reset;
   assign rr_next = (grant_idx == SELW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;

   for (genvar i = 0; i < NUM_REQS; i++) begin : g_ready
      assign in_ready[i] = fire && (grant_idx == SELW'(i));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_sel   <= '0;
         rr_ptr    <= '0;
         lock      <= 1'b0;
         lock_idx  <= '0;
      end else if (fire) begin
         out_valid <= 1'b1;
         out_sel   <= grant_idx;
         if (in_eop[grant_idx]) begin
            rr_ptr <= rr_next;
            lock   <= 1'b0;
         end else begin
            lock     <= 1'b1;
            lock_idx <= grant_idx;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Payload needs no reset; out_valid qualifies it.
   always_ff @(posedge clk) begin
      if (fire) out_data <= in_data[grant_idx];
   end

`ifdef VX_WB_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (reset)
         perf_stalls <= '0;
      else if (|(in_valid & ~in_ready))
         perf_stalls <= perf_stalls + 32'd1;
   end
`endif

endmodule
